// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state enumeration and the default operand width.
package mdu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_iter.sv
// One shift-add multiply step or one restoring-divide step on magnitudes.
// Purely combinational; no flow control.
// Multiply: {acc,low} is the product shifting right, low[0] is the current multiplier bit.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] low_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] low_o
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        addend = low_i[0] ? opnd_i : '0;
        sum    = {1'b0, acc_i} + {1'b0, addend};
        rem_sh = {acc_i, low_i[WIDTH-1]};
        fits   = rem_sh >= {1'b0, opnd_i};
        // Only the low bits matter: when the divisor fits, the true difference is below it.
        diff   = rem_sh[WIDTH-1:0] - opnd_i;

        if (is_div_i) begin
            acc_o = fits ? diff : rem_sh[WIDTH-1:0];
            low_o = {low_i[WIDTH-2:0], fits};
        end else begin
            acc_o = sum[WIDTH:1];
            low_o = {sum[0], low_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO write directly.
// Latency: busy for WIDTH+1 cycles, done pulses as busy falls; starts while busy are dropped.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, low_q, opnd_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             is_div_q, neg_res_q, neg_rem_q, div0_q;
    logic             busy_q, done_q;

    logic             op_arith, op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] acc_nx, low_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_hi_d, res_lo_d;

    always_comb begin
        op_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .low_i    (low_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_nx),
        .low_o    (low_nx)
    );

    // Sign correction of the final iteration's magnitude result.
    always_comb begin
        prod     = {acc_nx, low_nx};
        res_hi_d = acc_nx;
        res_lo_d = low_nx;
        if (!is_div_q) begin
            if (neg_res_q) begin
                prod = -prod;
            end
            res_hi_d = prod[2*WIDTH-1:WIDTH];
            res_lo_d = prod[WIDTH-1:0];
        end else begin
            if (neg_rem_q) begin
                res_hi_d = -acc_nx;
            end
            if (div0_q) begin
                res_lo_d = '1;
            end else if (neg_res_q) begin
                res_lo_d = -low_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            low_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        if (op_arith) begin
                            acc_q     <= '0;
                            low_q     <= op_div ? a_mag : b_mag;
                            opnd_q    <= op_div ? b_mag : a_mag;
                            is_div_q  <= op_div;
                            neg_res_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            div0_q    <= op_div && (b == '0);
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_RUN;
                        end else if (op == OP_MTHI) begin
                            hi_q <= a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CW'(WIDTH - 1)) begin
                        acc_q   <= res_hi_d;
                        low_q   <= res_lo_d;
                        state_q <= ST_FINISH;
                    end else begin
                        acc_q <= acc_nx;
                        low_q <= low_nx;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FINISH: begin
                    if (!cancel) begin
                        hi_q   <= acc_q;
                        lo_q   <= low_q;
                        done_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed vector table, random ops against an arithmetic model,
// and hand-written MTHI/MTLO, cancel and reset sequences.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: {hi,lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        res = '0;
        case (o)
            OP_MULT:  res = sx * sy;
            OP_MULTU: res = ux * uy;
            OP_DIV: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Issue one op and watch 45 cycles; sample 0 is the negedge after the accepting edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int busy_cyc, output int done_cnt, output int done_idx);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        busy_cyc = 0; done_cnt = 0; done_idx = -1;
        for (int i = 0; i < 45; i++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int bc, dc, di;
        logic [63:0] exp;
        logic [31:0] x, y, hold_hi, hold_lo;
        logic [2:0] o;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4] = '{OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, dc, di);
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
            chk($sformatf("vec%0d_done_count", i), 64'(dc), 64'd1);
            chk($sformatf("vec%0d_done_at", i), 64'(di), 64'd33);
        end

        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = $urandom_range(1, 15);
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
            exp = model(o, x, y);
            run_op(o, x, y, bc, dc, di);
            chk($sformatf("rand%0d_op%0d_%h_%h_hilo", i, o, x, y), {hi, lo}, exp);
            chk($sformatf("rand%0d_done_count", i), 64'(dc), 64'd1);
        end

        // MTHI / MTLO in IDLE write on the next edge without busy or done.
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);

        // Op 6 is a no-op; cancel beats a coincident start in IDLE.
        start = 1'b1; op = 3'd6; a = 32'h0BAD_0BAD;
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'h5555_5555; cancel = 1'b1;
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; op = 3'd7; cancel = 1'b0;
        chk("cancel_start_hi", 64'(hi), 64'hDEAD_BEEF);
        chk("cancel_start_busy", 64'(busy), 64'd0);

        // MTLO while busy is dropped; lo ends up with the MULT result.
        exp = model(OP_MULT, 32'h0000_1234, 32'hFFFF_0001);
        start = 1'b1; op = OP_MULT; a = 32'h0000_1234; b = 32'hFFFF_0001;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        repeat (3) @(negedge clk);
        start = 1'b1; op = OP_MTLO; a = 32'hCAFE_CAFE;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        repeat (40) @(negedge clk);
        chk("mtlo_busy_hilo", {hi, lo}, exp);

        // Cancel an in-flight MULT at cycle 5 with preloaded HI/LO.
        start = 1'b1; op = OP_MTHI; a = 32'h11;
        @(negedge clk);
        op = OP_MTLO; a = 32'h22;
        @(negedge clk);
        op = OP_MULT; a = 32'h7; b = 32'h9;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        repeat (4) @(negedge clk);
        chk("cancel_busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy_after", 64'(busy), 64'd0);
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dc++;
            @(negedge clk);
        end
        chk("cancel_no_done", 64'(dc), 64'd0);
        chk("cancel_hi", 64'(hi), 64'h11);
        chk("cancel_lo", 64'(lo), 64'h22);

        // Reset around iteration 10 of a DIV clears everything at once.
        start = 1'b1; op = OP_DIV; a = 32'h7FFF_0000; b = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_hi", 64'(hi), 64'd0);
        chk("midreset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        exp = model(OP_MULT, 32'hFFFF_FFF0, 32'h0000_0100);
        run_op(OP_MULT, 32'hFFFF_FFF0, 32'h0000_0100, bc, dc, di);
        chk("postreset_hilo", {hi, lo}, exp);
        chk("postreset_done_at", 64'(di), 64'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
